fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
Fetch-stage program-counter unit directly downstream of the exception/jump monitor. Consumes the monitor's redirect (J, J_R) and save request (Store_Current) and owns the PC register, next-PC selection and a small exception-return (EPC) stack. Executes return-from-exception pops. Produces the illegal-PC indication that feeds the monitor's Illegal_PC_in.

Parameters:
RESET_VECTOR, 16'h0000, PC value loaded on reset
USER_BASE, 16'h0400, lowest PC legal in user mode
EPC_DEPTH, 4, EPC stack entries (power of two, 2..8)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
J  in  1  redirect request from monitor
J_R  in  16  redirect target
Store_Current  in  1  push current PC and mode onto EPC stack with this redirect
rti  in  1  return-from-exception request from decode
stall  in  1  IF/ID stall; hold PC
Mode  in  2  current mode; Mode[1]=1 is privileged
pc  out  16  fetch address to instruction memory
pc_plus1  out  16  pc+1 to IF/ID register
flush_ifid  out  1  squash instruction in IF/ID
rti_mode  out  2  mode restored by an accepted rti; valid when rti_ack=1
rti_ack  out  1  rti accepted this cycle
illegal_pc  out  1  user-mode fetch below USER_BASE
epc_top  out  16  top-of-stack saved PC (0 when empty)
epc_count  out  $clog2(EPC_DEPTH)+1  stack occupancy
epc_overflow  out  1  sticky: push attempted while full

Behaviour:
- Reset (rst=1 at posedge): pc=RESET_VECTOR, epc_count=0, all entries 0, epc_overflow=0, pc_valid=0. Outputs during and after reset: flush_ifid=0, rti_ack=0, illegal_pc=0.
- pc_valid is internal. It sets to 1 on the first cycle after reset deasserts and stays 1.
- PC is word-addressed. pc_plus1 = pc+1, wraps 16'hFFFF to 16'h0000.
- Next-PC priority, registered at posedge:
  - rst
  - J: pc<=J_R
  - rti accepted: pc<=epc_top
  - stall: hold
  - otherwise pc<=pc+1
- J overrides stall. An rti coincident with J is dropped (rti_ack=0, no pop), because the instruction is being squashed.
- Push (J & Store_Current):
  - writes {pc, Mode} to stack[epc_count] and increments epc_count.
  - If full: no write, count unchanged, epc_overflow<=1. The redirect still happens.
  - Store_Current without J is ignored.
- rti acceptance:
  - Accepted when rti & ~J & ~stall & epc_count!=0.
  - rti_ack=1 combinationally and rti_mode=top mode field. The pop takes effect at the posedge.
  - rti with stall is not accepted; decode holds rti until unstalled.
  - rti with an empty stack: no pop, pc advances to pc+1, and illegal_pc is forced high that cycle.
- flush_ifid = J | rti_ack (combinational, same cycle).
- illegal_pc = pc_valid & ~Mode[1] & (pc < USER_BASE), OR the empty-stack rti case. Combinational; the monitor registers it.
- epc_top = stack[epc_count-1] PC field when epc_count>0, else 0.
- epc_overflow clears only on rst.
- Reset mid-operation clears the stack regardless of pending J, rti or stall.

Decomposition:
- Shared cpu package holds:
  - RESET_VECTOR and USER_BASE.
  - The mode encoding constants (MODE_PRIV_BIT=1, reset mode 2'b11).
  - A typedef for the EPC entry struct {pc[15:0], mode[1:0]}, also used by the monitor.
- One sub-module, epc_stack: a synchronous LIFO with push, pop, full, empty, top and sticky overflow, parameterised on EPC_DEPTH. The PC mux and illegal check stay in fetch_pc_unit.

Test Plan:
- Reset, then 3 cycles with no requests: pc goes 0000, 0001, 0002, 0003. illegal_pc=0 while Mode=11.
- pc=0010, stall=1 for 2 cycles, then J=1, J_R=0030, stall=1: pc holds 0010 twice, then pc=0030 and flush_ifid=1 in the J cycle.
- pc=0450, Mode=00, J=1, J_R=0030, Store_Current=1; next cycle Mode=10, rti=1: epc_top=0450 and epc_count=1 after the push. rti_ack=1, rti_mode=00, pc=0450, and epc_count=0 after the pop.
- Five pushes with EPC_DEPTH=4 (pcs 0401..0405): epc_count saturates at 4, epc_overflow=1, epc_top=0404. Four rti pops return 0404, 0403, 0402, 0401.
- Mode=00 and J_R=0100: the next cycle pc=0100 and illegal_pc=1. With Mode=10 at the same pc, illegal_pc=0.
- The same cycle has J=1 (J_R=0090) and rti=1 with epc_count=2: pc=0090, rti_ack=0, epc_count stays 2. Separately, rti with an empty stack gives illegal_pc=1 and pc+1.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared CPU definitions for the fetch PC unit and the exception/jump monitor.
// Holds the reset/user-space addresses, the mode encoding and the EPC stack entry layout.
package fetch_pc_unit_pkg;

    localparam logic [15:0] RESET_VECTOR  = 16'h0000;
    localparam logic [15:0] USER_BASE     = 16'h0400;

    localparam int          MODE_PRIV_BIT = 1;
    localparam logic [1:0]  MODE_RESET    = 2'b11;

    typedef struct packed {
        logic [15:0] pc;
        logic [1:0]  mode;
    } epc_entry_t;

    function automatic logic is_priv(input logic [1:0] mode);
        return mode[MODE_PRIV_BIT];
    endfunction

endpackage

// File: rtl/epc_stack.sv
// Synchronous LIFO of saved {pc, mode} entries with a sticky overflow flag.
// A push into a full stack is discarded and only sets the overflow flag.
module epc_stack
    import fetch_pc_unit_pkg::*;
#(
    parameter  int EPC_DEPTH = 4,
    localparam int IDX_W     = $clog2(EPC_DEPTH),
    localparam int CNT_W     = IDX_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  epc_entry_t       push_data,
    output epc_entry_t       top,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             overflow
);

    epc_entry_t       entries [EPC_DEPTH];
    logic             full;
    logic [IDX_W-1:0] top_idx;

    assign full    = (count == CNT_W'(EPC_DEPTH));
    assign empty   = (count == '0);
    assign top_idx = IDX_W'(count - CNT_W'(1));
    assign top     = empty ? '0 : entries[top_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < EPC_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (push) begin
            if (full) begin
                overflow <= 1'b1;
            end else begin
                entries[count[IDX_W-1:0]] <= push_data;
                count                     <= count + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC register, next-PC selection, EPC stack for exception return,
// and the illegal-PC indication returned to the exception/jump monitor.
module fetch_pc_unit #(
    parameter logic [15:0] RESET_VECTOR = fetch_pc_unit_pkg::RESET_VECTOR,
    parameter logic [15:0] USER_BASE    = fetch_pc_unit_pkg::USER_BASE,
    parameter int          EPC_DEPTH    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           J,
    input  logic [15:0]                    J_R,
    input  logic                           Store_Current,
    input  logic                           rti,
    input  logic                           stall,
    input  logic [1:0]                     Mode,
    output logic [15:0]                    pc,
    output logic [15:0]                    pc_plus1,
    output logic                           flush_ifid,
    output logic [1:0]                     rti_mode,
    output logic                           rti_ack,
    output logic                           illegal_pc,
    output logic [15:0]                    epc_top,
    output logic [$clog2(EPC_DEPTH):0]     epc_count,
    output logic                           epc_overflow
);
    import fetch_pc_unit_pkg::*;

    logic        pc_valid;
    logic        stack_empty;
    logic        rti_go;
    logic        rti_accept;
    logic        rti_fault;
    logic        push;
    logic [15:0] pc_next;
    epc_entry_t  push_entry;
    epc_entry_t  top_entry;

    assign push_entry = '{pc: pc, mode: Mode};
    assign push       = J & Store_Current;

    epc_stack #(
        .EPC_DEPTH (EPC_DEPTH)
    ) u_epc_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (rti_accept),
        .push_data (push_entry),
        .top       (top_entry),
        .count     (epc_count),
        .empty     (stack_empty),
        .overflow  (epc_overflow)
    );

    // An rti only executes when it is not being squashed by a redirect and not stalled.
    always_comb begin
        rti_go     = rti & ~J & ~stall;
        rti_accept = ~rst & rti_go & ~stack_empty;
        rti_fault  = ~rst & rti_go & stack_empty;
    end

    always_comb begin
        rti_ack    = rti_accept;
        rti_mode   = top_entry.mode;
        epc_top    = top_entry.pc;
        flush_ifid = ~rst & (J | rti_accept);
        illegal_pc = ~rst & ((pc_valid & ~is_priv(Mode) & (pc < USER_BASE)) | rti_fault);
        pc_plus1   = pc + 16'd1;
    end

    always_comb begin
        pc_next = pc_plus1;
        if (J) begin
            pc_next = J_R;
        end else if (rti_accept) begin
            pc_next = top_entry.pc;
        end else if (stall) begin
            pc_next = pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_VECTOR;
            pc_valid <= 1'b0;
        end else begin
            pc       <= pc_next;
            pc_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_fetch_pc_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, J, Store_Current, rti, stall;
    logic [15:0] J_R;
    logic [1:0]  Mode;

    logic [15:0] pc, pc_plus1, epc_top;
    logic        flush_ifid, rti_ack, illegal_pc, epc_overflow;
    logic [1:0]  rti_mode;
    logic [$clog2(DEPTH):0] epc_count;

    fetch_pc_unit #(
        .RESET_VECTOR (16'h0000),
        .USER_BASE    (16'h0400),
        .EPC_DEPTH    (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .J             (J),
        .J_R           (J_R),
        .Store_Current (Store_Current),
        .rti           (rti),
        .stall         (stall),
        .Mode          (Mode),
        .pc            (pc),
        .pc_plus1      (pc_plus1),
        .flush_ifid    (flush_ifid),
        .rti_mode      (rti_mode),
        .rti_ack       (rti_ack),
        .illegal_pc    (illegal_pc),
        .epc_top       (epc_top),
        .epc_count     (epc_count),
        .epc_overflow  (epc_overflow)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [15:0] m_pc;
    logic [15:0] m_spc   [DEPTH];
    logic [1:0]  m_smode [DEPTH];
    int          m_cnt;
    logic        m_ovf;
    logic        m_valid;
    bit          chk_en = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic ack;
        ack = !rst && rti && !J && !stall && (m_cnt != 0);
        if (rst) begin
            m_pc    = 16'h0000;
            m_cnt   = 0;
            m_ovf   = 1'b0;
            m_valid = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                m_spc[i]   = 16'h0;
                m_smode[i] = 2'b00;
            end
        end else begin
            m_valid = 1'b1;
            if (J) begin
                if (Store_Current) begin
                    if (m_cnt == DEPTH) m_ovf = 1'b1;
                    else begin
                        m_spc[m_cnt]   = m_pc;
                        m_smode[m_cnt] = Mode;
                        m_cnt++;
                    end
                end
                m_pc = J_R;
            end else if (ack) begin
                m_cnt--;
                m_pc = m_spc[m_cnt];
            end else if (!stall) begin
                m_pc = m_pc + 16'd1;
            end
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin : compare
            logic        e_ack, e_fault, e_ill;
            logic [15:0] e_top;
            e_ack   = !rst && rti && !J && !stall && (m_cnt != 0);
            e_fault = !rst && rti && !J && !stall && (m_cnt == 0);
            e_ill   = !rst && ((m_valid && !Mode[1] && (m_pc < 16'h0400)) || e_fault);
            e_top   = (m_cnt > 0) ? m_spc[m_cnt-1] : 16'h0000;
            cmp("pc",           pc,           m_pc);
            cmp("pc_plus1",     pc_plus1,     m_pc + 16'd1);
            cmp("flush_ifid",   flush_ifid,   16'(!rst && (J || e_ack)));
            cmp("rti_ack",      rti_ack,      16'(e_ack));
            cmp("illegal_pc",   illegal_pc,   16'(e_ill));
            cmp("epc_top",      epc_top,      e_top);
            cmp("epc_count",    epc_count,    16'(m_cnt));
            cmp("epc_overflow", epc_overflow, 16'(m_ovf));
            if (e_ack) cmp("rti_mode", rti_mode, 16'(m_smode[m_cnt-1]));
        end
    end

    task automatic drive(input logic r, input logic j, input logic [15:0] jr, input logic sc,
                         input logic ri, input logic st, input logic [1:0] md);
        rst = r; J = j; J_R = jr; Store_Current = sc; rti = ri; stall = st; Mode = md;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        // Reset with every request asserted: combinational outputs must stay quiet.
        drive(1, 1, 16'h1234, 1, 1, 1, 2'b00);
        cyc();
        chk_en = 1'b1;
        cmp("rst_flush",    flush_ifid,   16'h0);
        cmp("rst_rti_ack",  rti_ack,      16'h0);
        cmp("rst_illegal",  illegal_pc,   16'h0);
        cmp("rst_pc",       pc,           16'h0000);
        cmp("rst_count",    epc_count,    16'h0);
        cmp("rst_overflow", epc_overflow, 16'h0);
        cyc();

        // Free-running increment from the reset vector.
        drive(0, 0, 16'h0, 0, 0, 0, 2'b11);
        cmp("run_pc0", pc, 16'h0000);
        cmp("run_ill", illegal_pc, 16'h0);
        cyc(); cmp("run_pc1", pc, 16'h0001);
        cyc(); cmp("run_pc2", pc, 16'h0002);
        cyc(); cmp("run_pc3", pc, 16'h0003);

        // Stall holds, J overrides stall.
        drive(0, 1, 16'h0010, 0, 0, 0, 2'b11); cyc();
        drive(0, 0, 16'h0, 0, 0, 1, 2'b11);
        cyc(); cmp("stall_pc_a", pc, 16'h0010);
        cyc(); cmp("stall_pc_b", pc, 16'h0010);
        drive(0, 1, 16'h0030, 0, 0, 1, 2'b11);
        cmp("j_stall_flush", flush_ifid, 16'h1);
        cyc(); cmp("j_stall_pc", pc, 16'h0030);

        // Push on redirect from user mode, then return.
        drive(0, 1, 16'h0450, 0, 0, 0, 2'b11); cyc();
        drive(0, 1, 16'h0030, 1, 0, 0, 2'b00); cyc();
        cmp("push_top",   epc_top,   16'h0450);
        cmp("push_count", epc_count, 16'h1);
        drive(0, 0, 16'h0, 0, 1, 0, 2'b10);
        cmp("rti_ack",   rti_ack,    16'h1);
        cmp("rti_mode",  rti_mode,   16'h0);
        cmp("rti_flush", flush_ifid, 16'h1);
        cyc();
        cmp("rti_pc",    pc,         16'h0450);
        cmp("rti_count", epc_count,  16'h0);

        // Overflow: five pushes into a four-entry stack.
        drive(0, 1, 16'h0401, 0, 0, 0, 2'b10); cyc();
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 16'h0402 + 16'(k), 1, 0, 0, 2'b10);
            cyc();
        end
        cmp("ovf_count", epc_count,    16'h4);
        cmp("ovf_flag",  epc_overflow, 16'h1);
        cmp("ovf_top",   epc_top,      16'h0404);
        drive(0, 0, 16'h0, 0, 1, 0, 2'b10);
        for (int k = 0; k < 4; k++) begin
            cyc();
            cmp("pop_pc", pc, 16'h0404 - 16'(k));
        end

        // User-mode fetch below USER_BASE.
        drive(0, 1, 16'h0100, 0, 0, 0, 2'b00); cyc();
        drive(0, 0, 16'h0, 0, 0, 1, 2'b00);
        cmp("user_low_pc",  pc,         16'h0100);
        cmp("user_low_ill", illegal_pc, 16'h1);
        drive(0, 0, 16'h0, 0, 0, 1, 2'b10);
        cmp("priv_low_ill", illegal_pc, 16'h0);

        // rti coincident with J is dropped; then empty-stack rti.
        drive(0, 1, 16'h0200, 1, 0, 0, 2'b10); cyc();
        drive(0, 1, 16'h0300, 1, 0, 0, 2'b10); cyc();
        drive(0, 1, 16'h0090, 0, 1, 0, 2'b10);
        cmp("jrti_ack", rti_ack, 16'h0);
        cyc();
        cmp("jrti_pc",    pc,        16'h0090);
        cmp("jrti_count", epc_count, 16'h2);
        drive(0, 0, 16'h0, 0, 1, 0, 2'b10);
        cyc(); cmp("pop2_pc", pc, 16'h0200);
        cyc(); cmp("pop1_pc", pc, 16'h0100);
        cmp("empty_rti_ill", illegal_pc, 16'h1);
        cmp("empty_rti_ack", rti_ack,    16'h0);
        cyc(); cmp("empty_rti_pc", pc, 16'h0101);

        // PC wrap at the top of the address space.
        drive(0, 1, 16'hFFFF, 0, 0, 0, 2'b11); cyc();
        drive(0, 0, 16'h0, 0, 0, 0, 2'b11);
        cmp("wrap_plus1", pc_plus1, 16'h0000);
        cyc(); cmp("wrap_pc", pc, 16'h0000);

        // Randomized traffic against the model, including mid-run resets.
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] jr;
            jr = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom & 32'h07FF);
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 4) == 0), jr,
                  1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  2'($urandom));
            cyc();
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
